// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x-oversampling UART receiver with configurable frame and FWFT RX FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          busy
);

  localparam int DIV = CLK_FREQ_HZ / (BAUD * 16);
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  logic                 rxd_s1, rxd_s2, rxd_prev;
  logic                 fall;
  state_t               state;
  logic [CW-1:0]        tick_cnt;
  logic                 tick;
  logic [3:0]           os;
  logic                 s7, s8, bit_val;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr, push;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  assign fall    = rxd_prev & ~rxd_s2;
  assign tick    = (tick_cnt == CW'(DIV - 1));
  assign bit_val = (s7 & s8) | (s7 & rxd_s2) | (s8 & rxd_s2);

  // Samples at os=7/8/9 resolve each bit on os=9; os=15 moves to the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      os       <= '0;
      s7       <= 1'b0;
      s8       <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      push     <= 1'b0;
    end else begin
      push     <= 1'b0;
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            tick_cnt <= '0;
            os       <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        BRK: begin
          if (rxd_s2) state <= IDLE;
        end
        default: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd7) s7 <= rxd_s2;
            if (os == 4'd8) s8 <= rxd_s2;
            if (os == 4'd9) begin
              case (state)
                START: if (bit_val) state <= IDLE;
                DATA:  shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                PAR:   perr <= (bit_val != ((^shreg) ^ ODD));
                STOP: begin
                  if (!bit_val) ferr <= 1'b1;
                  if (stop_idx == 1'(STOP_BITS - 1)) begin
                    push  <= 1'b1;
                    // A line still held low after a bad stop bit is a break.
                    state <= ((ferr | ~bit_val) & ~rxd_s2) ? BRK : IDLE;
                  end
                end
                default: ;
              endcase
            end
            if (os == 4'd15) begin
              case (state)
                START: state <= DATA;
                DATA: begin
                  if (bit_idx == 3'(DATA_BITS - 1))
                    state <= (PARITY != 0) ? PAR : STOP;
                  else
                    bit_idx <= bit_idx + 3'd1;
                end
                PAR:   state <= STOP;
                STOP:  stop_idx <= 1'b1;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {perr, ferr, shreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push & full & ~pop) overrun <= 1'b1;
      else if (overrun_clr)   overrun <= 1'b0;
    end
  end

  assign {rx_perr, rx_ferr, rx_data} = rx_valid ? mem[rd_ptr] : '0;
  assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo (8N1 and 8E1 instances, DIV=4)
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 15625;
  localparam int BIT    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_rxd = 1'b1, a_ready = 1'b0, a_oclr = 1'b0;
  logic [7:0] a_data;
  logic       a_perr, a_ferr, a_valid, a_overrun, a_busy;
  logic [4:0] a_count;

  logic       b_rxd = 1'b1, b_ready = 1'b0, b_oclr = 1'b0;
  logic [7:0] b_data;
  logic       b_perr, b_ferr, b_valid, b_overrun, b_busy;
  logic [4:0] b_count;

  uart_rx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .rxd(a_rxd), .rx_data(a_data), .rx_perr(a_perr),
    .rx_ferr(a_ferr), .rx_valid(a_valid), .rx_ready(a_ready), .rx_count(a_count),
    .overrun(a_overrun), .overrun_clr(a_oclr), .busy(a_busy));

  uart_rx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .rxd(b_rxd), .rx_data(b_data), .rx_perr(b_perr),
    .rx_ferr(b_ferr), .rx_valid(b_valid), .rx_ready(b_ready), .rx_count(b_count),
    .overrun(b_overrun), .overrun_clr(b_oclr), .busy(b_busy));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) a_rxd = v;
    else            b_rxd = v;
  endtask

  task automatic send_bit(input int which, input logic v);
    set_line(which, v);
    hold(BIT);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit par_en, input logic pbit);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, d[i]);
    if (par_en) send_bit(which, pbit);
    send_bit(which, 1'b1);
  endtask

  task automatic pop_a();
    a_ready = 1'b1;
    hold(1);
    a_ready = 1'b0;
  endtask

  task automatic pop_b();
    b_ready = 1'b1;
    hold(1);
    b_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    hold(3);
    rst = 1'b0;
    hold(2);
    check("reset_valid",   a_valid, 0);
    check("reset_count",   a_count, 0);
    check("reset_busy",    a_busy, 0);
    check("reset_overrun", a_overrun, 0);
    check("reset_data",    a_data, 0);

    // 8N1 0xA5: not pushed before the stop bit, pushed well before it ends
    send_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(0, a5[i]);
    check("a5_early_valid", a_valid, 0);
    set_line(0, 1'b1);
    hold(48);
    check("a5_valid", a_valid, 1);
    check("a5_data",  a_data, 8'hA5);
    check("a5_perr",  a_perr, 0);
    check("a5_ferr",  a_ferr, 0);
    check("a5_count", a_count, 1);
    hold(16);
    pop_a();
    check("a5_pop_count", a_count, 0);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1
    send_frame(1, 8'h37, 1'b1, 1'b1);
    send_frame(1, 8'h37, 1'b1, 1'b0);
    check("par_count",  b_count, 2);
    check("par1_data",  b_data, 8'h37);
    check("par1_perr",  b_perr, 0);
    pop_b();
    check("par2_data",  b_data, 8'h37);
    check("par2_perr",  b_perr, 1);
    check("par2_ferr",  b_ferr, 0);
    pop_b();

    // Break: stop bit held low for 10 bit times
    send_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(0, 1'b0);
    hold(10 * BIT);
    check("brk_busy",  a_busy, 1);
    check("brk_count", a_count, 1);
    check("brk_data",  a_data, 8'h00);
    check("brk_ferr",  a_ferr, 1);
    set_line(0, 1'b1);
    hold(8);
    check("brk_idle",  a_busy, 0);
    hold(2 * BIT);
    check("brk_single", a_count, 1);
    pop_a();

    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 1'b0, 1'b0);
    check("ovr_count", a_count, 16);
    check("ovr_flag",  a_overrun, 1);
    check("ovr_head",  a_data, 8'h00);
    a_oclr = 1'b1;
    hold(1);
    a_oclr = 1'b0;
    check("ovr_clr", a_overrun, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_pop%0d", i), a_data, 32'(i));
      pop_a();
    end
    check("ovr_empty", a_count, 0);

    // Glitch shorter than the mid-start sample point
    set_line(0, 1'b0);
    hold(10);
    check("glitch_busy", a_busy, 1);
    hold(10);
    set_line(0, 1'b1);
    hold(40);
    check("glitch_idle",  a_busy, 0);
    check("glitch_valid", a_valid, 0);
    hold(10 * BIT);
    check("glitch_nopush", a_count, 0);

    // Reset during a data bit, with an entry already queued
    send_frame(0, 8'h11, 1'b0, 1'b0);
    check("pre_rst_valid", a_valid, 1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    hold(BIT / 2);
    check("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    check("rst_busy",  a_busy, 0);
    check("rst_valid", a_valid, 0);
    hold(12 * BIT);
    send_frame(0, 8'h5A, 1'b0, 1'b0);
    check("post_rst_count", a_count, 1);
    check("post_rst_data",  a_data, 8'h5A);
    check("post_rst_perr",  a_perr, 0);
    check("post_rst_ferr",  a_ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
